keypad_digit_collector: RTL and testbench

- Producer side of the digit-packet interface consumed by the setup and lock-operation FSMs.
- Converts debounced keypad key events into a 20-digit `senhaPac_t` packet (`digitos_value`) with a one-cycle `digitos_valid` strobe.
- Shows the partial entry live on `digitos_value` while typing, so consumers can display it.
- Sits between the keypad scanner/debouncer and the setup/operation blocks.

---
 rtl/keypad_digit_collector_pkg.sv | 31 +++
 rtl/keypad_digit_collector_inactivity_timer.sv | 41 ++++
 rtl/keypad_digit_collector.sv | 149 ++++++++++++++
 tb/tb_keypad_digit_collector.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_digit_collector_pkg.sv
// -----------------------------------------------------------------------------
// keypad_digit_collector_pkg
// Shared types and constants for the keypad digit-packet interface.
//   senhaPac_t  : 20 packed BCD digits, digits[0] is the newest digit.
//   KEY_*       : special key codes delivered by the keypad debouncer.
//   PKT_*       : fixed packets that consumers decode as commands.
//   is_digit    : true for key codes 0-9.
//   shift_in    : pushes a new digit into position 0, oldest falls off.
// -----------------------------------------------------------------------------
package keypad_digit_collector_pkg;

    localparam int NUM_DIGITS = 20;

    typedef logic [NUM_DIGITS-1:0][3:0] senhaPac_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;

    localparam senhaPac_t PKT_EMPTY   = {NUM_DIGITS{4'hF}};
    localparam senhaPac_t PKT_BACK    = {NUM_DIGITS{4'hB}};
    localparam senhaPac_t PKT_TIMEOUT = {NUM_DIGITS{4'hE}};

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    function automatic senhaPac_t shift_in(input senhaPac_t pkt, input logic [3:0] digit);
        return {pkt[NUM_DIGITS-2:0], digit};
    endfunction

endpackage

// File: rtl/keypad_digit_collector_inactivity_timer.sv
// -----------------------------------------------------------------------------
// keypad_digit_collector_inactivity_timer
// Counts idle cycles while the collector holds a partial entry.
//   clk    : system clock
//   rst    : synchronous active-low reset
//   clear  : restart the count from zero (has priority over run)
//   run    : count this cycle
//   expire : high while running with the count at TIMEOUT_CYCLES-1, so the
//            owner acts on the edge that would complete the timeout period
// -----------------------------------------------------------------------------
module keypad_digit_collector_inactivity_timer #(
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] LAST_COUNT = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] count_r;

    // Idle-cycle counter; parks at the last value so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (run && (count_r != LAST_COUNT)) begin
            count_r <= count_r + TMR_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = run && (count_r == LAST_COUNT);

endmodule

// File: rtl/keypad_digit_collector.sv
// -----------------------------------------------------------------------------
// keypad_digit_collector
// Turns debounced keypad presses into a 20-digit packet with a one-cycle
// valid strobe. The partial entry is shown live on digitos_value.
//   clk            : system clock, all logic on posedge
//   rst            : synchronous active-low reset
//   enable         : 0 holds the collector empty and ignores keys
//   key_valid      : level, high while a debounced key is pressed
//   key_code       : 0-9 digit, A enter, B back, others ignored
//   digitos_value  : live buffer, or the final packet while digitos_valid=1
//   digitos_valid  : one-cycle strobe marking the final packet
//   digit_count    : digits currently buffered, 0..20
// -----------------------------------------------------------------------------
module keypad_digit_collector
    import keypad_digit_collector_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid,
    output logic [4:0] digit_count
);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;
    localparam logic [4:0] MAX_COUNT  = 5'd20;

    logic [1:0] state_r;
    logic [1:0] state_s;
    senhaPac_t  pkt_r;
    senhaPac_t  pkt_s;
    logic [4:0] count_r;
    logic [4:0] count_s;
    logic       valid_r;
    logic       valid_s;
    logic       key_valid_q_r;
    logic       key_event_s;
    logic       digit_event_s;
    logic       timer_clear_s;
    logic       timer_run_s;
    logic       timer_expire_s;

    // A held key yields a single event on its rising level.
    assign key_event_s   = key_valid && !key_valid_q_r;
    assign digit_event_s = key_event_s && is_digit(key_code) && (state_r == ST_COLLECT);

    // Any accepted digit restarts the idle period, even when the buffer is full.
    assign timer_run_s   = (state_r == ST_COLLECT);
    assign timer_clear_s = !enable || (state_r != ST_COLLECT) || digit_event_s;

    keypad_digit_collector_inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear_s),
        .run    (timer_run_s),
        .expire (timer_expire_s)
    );

    // Next-state logic: key events outrank the timeout in the same cycle.
    always_comb begin
        state_s = state_r;
        pkt_s   = pkt_r;
        count_s = count_r;
        valid_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (key_event_s && is_digit(key_code)) begin
                    pkt_s   = shift_in(PKT_EMPTY, key_code);
                    count_s = 5'd1;
                    state_s = ST_COLLECT;
                end else if (key_event_s && (key_code == KEY_ENTER)) begin
                    pkt_s   = PKT_EMPTY;
                    valid_s = 1'b1;
                    state_s = ST_EMIT;
                end else if (key_event_s && (key_code == KEY_BACK)) begin
                    pkt_s   = PKT_BACK;
                    valid_s = 1'b1;
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_COLLECT: begin
                if (digit_event_s) begin
                    if (count_r < MAX_COUNT) begin
                        pkt_s   = shift_in(pkt_r, key_code);
                        count_s = count_r + 5'd1;
                    end else begin
                        pkt_s   = pkt_r;
                    end
                end else if (key_event_s && (key_code == KEY_ENTER)) begin
                    valid_s = 1'b1;
                    state_s = ST_EMIT;
                end else if (key_event_s && (key_code == KEY_BACK)) begin
                    pkt_s   = PKT_BACK;
                    valid_s = 1'b1;
                    state_s = ST_EMIT;
                end else if (timer_expire_s) begin
                    pkt_s   = PKT_TIMEOUT;
                    valid_s = 1'b1;
                    state_s = ST_EMIT;
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                // Keys arriving while the packet is on the bus are dropped.
                pkt_s   = PKT_EMPTY;
                count_s = 5'd0;
                state_s = ST_EMPTY;
            end
            default: begin
                pkt_s   = PKT_EMPTY;
                count_s = 5'd0;
                state_s = ST_EMPTY;
            end
        endcase
    end

    // State and output registers; disable aborts an entry with no strobe.
    always_ff @(posedge clk) begin
        if (!rst || !enable) begin
            state_r       <= ST_EMPTY;
            pkt_r         <= PKT_EMPTY;
            count_r       <= 5'd0;
            valid_r       <= 1'b0;
            key_valid_q_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            pkt_r         <= pkt_s;
            count_r       <= count_s;
            valid_r       <= valid_s;
            key_valid_q_r <= key_valid;
        end
    end

    assign digitos_value = pkt_r;
    assign digitos_valid = valid_r;
    assign digit_count   = count_r;

endmodule

// File: tb/tb_keypad_digit_collector.sv
// -----------------------------------------------------------------------------
// tb_keypad_digit_collector
// Directed scenarios plus a randomized run, checked against a queue-based
// model of the collector kept in the bench. TIMEOUT_CYCLES is 100 here.
// -----------------------------------------------------------------------------
module tb_keypad_digit_collector;

    localparam int TO = 100;
    localparam logic [79:0] ALL_F = {20{4'hF}};
    localparam logic [79:0] ALL_B = {20{4'hB}};
    localparam logic [79:0] ALL_E = {20{4'hE}};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic [79:0] dv;
    logic        dv_valid;
    logic [4:0]  dcount;

    int n_err = 0;
    int n_checks = 0;
    int n_pulses = 0;
    logic [79:0] last_pkt = '0;

    // Reference model: buffered digits newest-first, plus a pending packet.
    int          q[$];
    bit          m_kq = 1'b0;
    bit          m_emit = 1'b0;
    logic [79:0] m_pkt = '0;
    int          m_idle = 0;

    keypad_digit_collector #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .digitos_value (dv),
        .digitos_valid (dv_valid),
        .digit_count   (dcount)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] model_pack();
        logic [79:0] v;
        v = ALL_F;
        for (int i = 0; i < q.size(); i++) v[i*4 +: 4] = 4'(q[i]);
        return v;
    endfunction

    task automatic model_edge();
        bit ev;
        ev = key_valid && !m_kq;
        if (!rst || !enable) begin
            q.delete(); m_kq = 1'b0; m_emit = 1'b0; m_idle = 0;
        end else begin
            m_kq = key_valid;
            if (m_emit) begin
                m_emit = 1'b0; q.delete(); m_idle = 0;
            end else if (ev && key_code <= 4'd9) begin
                if (q.size() < 20) q.push_front(int'(key_code));
                m_idle = 0;
            end else if (ev && key_code == 4'hA) begin
                m_emit = 1'b1; m_pkt = model_pack();
            end else if (ev && key_code == 4'hB) begin
                m_emit = 1'b1; m_pkt = ALL_B;
            end else if (q.size() > 0) begin
                m_idle++;
                if (m_idle >= TO) begin m_emit = 1'b1; m_pkt = ALL_E; end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (dv_valid === 1'b1) begin
            n_pulses++;
            last_pkt = dv;
        end
    endtask

    task automatic press(input logic [3:0] code, input int hold, input int gap);
        key_code = code;
        key_valid = 1'b1;
        repeat (hold) tick();
        key_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; key_code = 4'd5; key_valid = 1'b1;
        tick(); tick();
        n_checks++; if (dv_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", dv_valid); end
        n_checks++; if (dv !== ALL_F) begin n_err++; $display("FAIL reset_value: got %h expected %h", dv, ALL_F); end
        n_checks++; if (dcount !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", dcount); end
        rst = 1'b1; key_valid = 1'b0;
        tick();
    endtask

    task automatic test_basic_entry();
        logic [79:0] exp;
        exp = ALL_F;
        n_pulses = 0;
        for (int i = 1; i <= 4; i++) begin
            press(4'(i), 3, 2);
            exp = {exp[75:0], 4'(i)};
            n_checks++; if (dv !== exp) begin n_err++; $display("FAIL partial_%0d: got %h expected %h", i, dv, exp); end
            n_checks++; if (dcount !== 5'(i)) begin n_err++; $display("FAIL partial_count_%0d: got %0d expected %0d", i, dcount, i); end
        end
        key_code = 4'hA; key_valid = 1'b1;
        tick();
        n_checks++; if (dv_valid !== 1'b1) begin n_err++; $display("FAIL enter_valid: got %b expected 1", dv_valid); end
        n_checks++; if (dv !== {64'hFFFF_FFFF_FFFF_FFFF, 16'h1234}) begin n_err++; $display("FAIL enter_pkt: got %h expected ffff..1234", dv); end
        tick();
        n_checks++; if (dv_valid !== 1'b0 || dv !== ALL_F || dcount !== 5'd0) begin
            n_err++; $display("FAIL after_emit: got valid=%b value=%h count=%0d expected 0/all-F/0", dv_valid, dv, dcount);
        end
        key_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (n_pulses !== 1) begin n_err++; $display("FAIL enter_pulses: got %0d expected 1", n_pulses); end
    endtask

    task automatic test_enter_back();
        n_pulses = 0;
        press(4'hA, 2, 2);
        n_checks++; if (n_pulses !== 1 || last_pkt !== ALL_F) begin n_err++; $display("FAIL empty_enter: got pulses=%0d pkt=%h expected 1/all-F", n_pulses, last_pkt); end
        press(4'd5, 1, 1);
        press(4'd6, 1, 1);
        n_checks++; if (dcount !== 5'd2) begin n_err++; $display("FAIL two_digits: got %0d expected 2", dcount); end
        n_pulses = 0;
        press(4'hB, 2, 2);
        n_checks++; if (n_pulses !== 1 || last_pkt !== ALL_B) begin n_err++; $display("FAIL back: got pulses=%0d pkt=%h expected 1/all-B", n_pulses, last_pkt); end
        n_checks++; if (dcount !== 5'd0) begin n_err++; $display("FAIL back_count: got %0d expected 0", dcount); end
    endtask

    task automatic test_saturation();
        logic [79:0] exp;
        int d;
        for (int i = 0; i < 22; i++) begin
            d = (i < 20) ? (i % 10) : ((i == 20) ? 7 : 8);
            press(4'(d), 1, 1);
        end
        n_checks++; if (dcount !== 5'd20) begin n_err++; $display("FAIL sat_count: got %0d expected 20", dcount); end
        for (int i = 0; i < 20; i++) exp[(19 - i)*4 +: 4] = 4'(i % 10);
        n_pulses = 0;
        press(4'hA, 1, 2);
        n_checks++; if (n_pulses !== 1 || last_pkt !== exp) begin n_err++; $display("FAIL sat_pkt: got pulses=%0d pkt=%h expected 1/%h", n_pulses, last_pkt, exp); end
    endtask

    task automatic test_timeout();
        logic [79:0] exp;
        n_pulses = 0;
        press(4'd9, 1, 0);
        repeat (TO - 1) tick();
        n_checks++; if (n_pulses !== 0) begin n_err++; $display("FAIL early_timeout: got %0d pulses expected 0", n_pulses); end
        tick();
        n_checks++; if (dv_valid !== 1'b1 || dv !== ALL_E) begin n_err++; $display("FAIL timeout_pkt: got valid=%b value=%h expected 1/all-E", dv_valid, dv); end
        tick();
        n_checks++; if (dcount !== 5'd0 || dv !== ALL_F) begin n_err++; $display("FAIL timeout_after: got count=%0d value=%h expected 0/all-F", dcount, dv); end
        n_pulses = 0;
        press(4'd9, 1, 0);
        repeat (TO - 1) tick();
        press(4'd3, 1, 0);
        exp = {ALL_F[79:8], 8'h93};
        n_checks++; if (n_pulses !== 0) begin n_err++; $display("FAIL cancel_pulse: got %0d pulses expected 0", n_pulses); end
        n_checks++; if (dv !== exp || dcount !== 5'd2) begin n_err++; $display("FAIL cancel_buffer: got %h/%0d expected %h/2", dv, dcount, exp); end
        repeat (TO - 1) tick();
        n_checks++; if (n_pulses !== 0) begin n_err++; $display("FAIL restart_early: got %0d pulses expected 0", n_pulses); end
        tick();
        n_checks++; if (dv_valid !== 1'b1 || dv !== ALL_E) begin n_err++; $display("FAIL restart_timeout: got valid=%b value=%h expected 1/all-E", dv_valid, dv); end
        tick();
    endtask

    task automatic test_held_key();
        logic [79:0] exp;
        press(4'd7, 50, 2);
        exp = {ALL_F[79:4], 4'h7};
        n_checks++; if (dcount !== 5'd1 || dv !== exp) begin n_err++; $display("FAIL held_key: got %0d/%h expected 1/%h", dcount, dv, exp); end
        press(4'hC, 3, 2);
        n_checks++; if (dcount !== 5'd1 || dv !== exp) begin n_err++; $display("FAIL ignored_code: got %0d/%h expected 1/%h", dcount, dv, exp); end
        press(4'hA, 1, 2);
    endtask

    task automatic test_abort();
        n_pulses = 0;
        press(4'd1, 1, 1); press(4'd2, 1, 1); press(4'd3, 1, 1);
        rst = 1'b0; tick(); rst = 1'b1;
        n_checks++; if (dv !== ALL_F || dcount !== 5'd0 || dv_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset: got %h/%0d/%b expected all-F/0/0", dv, dcount, dv_valid); end
        press(4'd4, 1, 1); press(4'd5, 1, 1);
        enable = 1'b0; tick(); enable = 1'b1;
        n_checks++; if (dv !== ALL_F || dcount !== 5'd0 || dv_valid !== 1'b0) begin n_err++; $display("FAIL mid_disable: got %h/%0d/%b expected all-F/0/0", dv, dcount, dv_valid); end
        tick();
        n_checks++; if (n_pulses !== 0) begin n_err++; $display("FAIL abort_pulses: got %0d expected 0", n_pulses); end
        press(4'd1, 1, 0);
        repeat (TO) tick();
        n_checks++; if (dv_valid !== 1'b1) begin n_err++; $display("FAIL emit_setup: got %b expected 1", dv_valid); end
        key_code = 4'd5; key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
        n_checks++; if (dcount !== 5'd0 || dv !== ALL_F) begin n_err++; $display("FAIL key_in_emit: got %0d/%h expected 0/all-F", dcount, dv); end
    endtask

    task automatic test_random();
        int idle_left;
        int r;
        idle_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (idle_left > 0) begin
                key_valid = 1'b0;
                idle_left--;
            end else begin
                if ($urandom_range(0, 2) == 0) begin
                    if (!key_valid) begin
                        r = $urandom_range(0, 99);
                        if (r < 80)      key_code = 4'(r % 10);
                        else if (r < 88) key_code = 4'hA;
                        else if (r < 94) key_code = 4'hB;
                        else             key_code = 4'hC + 4'(r % 4);
                    end
                    key_valid = ~key_valid;
                end
                if ($urandom_range(0, 299) == 0) idle_left = $urandom_range(95, 120);
            end
            enable = ($urandom_range(0, 299) != 0);
            tick();
            n_checks++; if (dv_valid !== m_emit) begin n_err++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, dv_valid, m_emit); end
            n_checks++; if (dv !== (m_emit ? m_pkt : model_pack())) begin n_err++; $display("FAIL rnd_value@%0d: got %h expected %h", c, dv, (m_emit ? m_pkt : model_pack())); end
            if (!m_emit) begin
                n_checks++; if (dcount !== 5'(q.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, dcount, q.size()); end
            end
        end
        enable = 1'b1; key_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_entry();
        test_enter_back();
        test_saturation();
        test_timeout();
        test_held_key();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
